// File: rtl/lights_out_pkg.sv
// Shared definitions for the lights-out button front end: button count,
// conditioner FSM states and move-counter width.
package lights_out_pkg;

    localparam int N_BUTTONS    = 9;
    localparam int MOVE_COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        WAIT_RELEASE
    } btn_state_t;

    // True when more than one bit is set (a chord of simultaneous rises).
    function automatic logic multi_hot(input logic [N_BUTTONS-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/lights_out_debounce.sv
// One button: 2-flop synchroniser, stability counter, debounced level and a
// registered rise pulse that is aligned with the level changing 0->1.
module lights_out_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Synchroniser stage: runs regardless of ena so it never holds stale metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign cnt_inc = cnt + 1'b1;

    // Debounce stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else if (ena) begin
            rise <= 1'b0;
            if (sync_p1 != level) begin
                if (cnt_inc == CNT_LAST) begin
                    level <= sync_p1;
                    rise  <= sync_p1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lights_out_button_conditioner.sv
// Nine debounced buttons feeding a single-move arbiter with valid/ready output.
// Optional saturating accepted-move counter: define LIGHTS_OUT_MOVE_COUNT_EN.
module lights_out_button_conditioner
    import lights_out_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [N_BUTTONS-1:0]    btn_raw,
    output logic [N_BUTTONS-1:0]    press_onehot,
    output logic                    press_valid,
    input  logic                    press_ready
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
    ,
    output logic [MOVE_COUNT_W-1:0] move_count
`endif
);

    logic [N_BUTTONS-1:0] level;
    logic [N_BUTTONS-1:0] rise;
    btn_state_t           state;
    btn_state_t           state_next;
    logic [N_BUTTONS-1:0] onehot_next;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
        lights_out_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .ena    (ena),
            .btn_raw(btn_raw[g]),
            .level  (level[g]),
            .rise   (rise[g])
        );
    end

    // Arbitration stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            press_onehot <= '0;
        end else if (ena) begin
            state        <= state_next;
            press_onehot <= onehot_next;
        end
    end

    always_comb begin
        state_next  = state;
        onehot_next = press_onehot;
        case (state)
            IDLE: begin
                if (rise != '0) begin
                    if (multi_hot(rise)) begin
                        state_next = WAIT_RELEASE;
                    end else begin
                        onehot_next = rise;
                        state_next  = EMIT;
                    end
                end
            end
            EMIT: begin
                if (press_ready) begin
                    onehot_next = '0;
                    state_next  = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                // Rises arriving here belong to a held or chorded press and are dropped.
                if (level == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                onehot_next = '0;
                state_next  = IDLE;
            end
        endcase
    end

    // Decoded from state so an asynchronous reset drops it immediately.
    assign press_valid = (state == EMIT);

`ifdef LIGHTS_OUT_MOVE_COUNT_EN
    logic transfer;

    assign transfer = press_valid & press_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_count <= '0;
        end else if (ena && transfer && (move_count != '1)) begin
            move_count <= move_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lights_out_button_conditioner.sv
// Bench for lights_out_button_conditioner: vector table, directed corner cases,
// and randomized traffic against a window-based reference model.
module tb_lights_out_button_conditioner;
    import lights_out_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [8:0] btn_raw = '0;
    logic       press_ready = 1'b0;
    logic [8:0] press_onehot;
    logic       press_valid;
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
    logic [7:0] move_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_moves = 0;

    always #5 clk = ~clk;

    lights_out_button_conditioner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .btn_raw     (btn_raw),
        .press_onehot(press_onehot),
        .press_valid (press_valid),
        .press_ready (press_ready)
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
        ,
        .move_count  (move_count)
`endif
    );

    // Reference model: a button's level flips once its last D enabled synced
    // samples all disagree with it and at least D enabled samples have passed
    // since its previous flip. m_state: 0 idle, 1 emitting, 2 waiting release.
    logic [8:0]   m_d1, m_d2, m_lvl, m_rise, m_oh;
    logic [D-1:0] m_win [9];
    int           m_age [9];
    int           m_state;
    int           m_cnt;

    always @(posedge clk or negedge rst_n) begin : model
        logic [8:0] synced;
        logic [8:0] new_rise;
        if (!rst_n) begin
            m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0; m_oh = '0;
            m_state = 0; m_cnt = 0;
            for (int i = 0; i < 9; i++) begin
                m_win[i] = '0;
                m_age[i] = 0;
            end
        end else begin
            synced = m_d2;
            m_d2 = m_d1;
            m_d1 = btn_raw;
            if (ena) begin
                case (m_state)
                    0: if ($countones(m_rise) == 1) begin
                           m_state = 1;
                           m_oh = m_rise;
                       end else if ($countones(m_rise) > 1) begin
                           m_state = 2;
                       end
                    1: if (press_ready) begin
                           m_state = 2;
                           m_oh = '0;
                           if (m_cnt < 255) m_cnt++;
                       end
                    default: if (m_lvl == '0) m_state = 0;
                endcase
                new_rise = '0;
                for (int i = 0; i < 9; i++) begin
                    m_win[i] = {m_win[i][D-2:0], synced[i]};
                    if (m_age[i] < D) m_age[i]++;
                    if (m_age[i] >= D && m_win[i] == {D{~m_lvl[i]}}) begin
                        m_lvl[i] = ~m_lvl[i];
                        new_rise[i] = m_lvl[i];
                        m_age[i] = 0;
                    end
                end
                m_rise = new_rise;
            end
        end
    end

    typedef struct {
        logic [8:0] btn;
        logic       rdy;
        logic       vld;
        logic [8:0] oh;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [8:0] b, input logic r, input logic v, input logic [8:0] o);
        vec_t e;
        e.btn = b; e.rdy = r; e.vld = v; e.oh = o;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [8:0] b, input logic r);
        btn_raw = b;
        press_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        repeat (D + 4) step('0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_out(input string name, input logic v, input logic [8:0] o);
        check({name, "_valid"}, {31'b0, press_valid}, {31'b0, v});
        check({name, "_onehot"}, {23'b0, press_onehot}, {23'b0, o});
    endtask

    initial begin
        logic [8:0] pat;
        int hold;

        // Clean press on bit 4, then release, then a bouncing press on bit 0
        for (int j = 0; j < 12; j++) add(9'h010, 1'b1, j == 6, (j == 6) ? 9'h010 : 9'h000);
        for (int j = 0; j < 8; j++)  add(9'h000, 1'b1, 1'b0, 9'h000);
        add(9'h001, 1'b1, 1'b0, '0); add(9'h000, 1'b1, 1'b0, '0);
        add(9'h001, 1'b1, 1'b0, '0); add(9'h001, 1'b1, 1'b0, '0);
        add(9'h000, 1'b1, 1'b0, '0);
        for (int j = 0; j < 10; j++) add(9'h001, 1'b1, j == 6, (j == 6) ? 9'h001 : 9'h000);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 9'h000);
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
        check("reset_count", {24'b0, move_count}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].btn, tbl[i].rdy);
            check_out("table", tbl[i].vld, tbl[i].oh);
        end
        exp_moves = 2;
        release_all();

        // Backpressure with the button released while waiting
        for (int j = 0; j < 6; j++) step(9'h100, 1'b0);
        check_out("bp_pre", 1'b0, 9'h000);
        step(9'h100, 1'b0);
        check_out("bp_emit", 1'b1, 9'h100);
        for (int j = 0; j < 10; j++) begin
            step(9'h000, 1'b0);
            check_out("bp_hold", 1'b1, 9'h100);
        end
        step(9'h000, 1'b1);
        check_out("bp_xfer", 1'b0, 9'h000);
        exp_moves++;
        repeat (3) begin
            step(9'h000, 1'b1);
            check_out("bp_after", 1'b0, 9'h000);
        end
        release_all();

        // Chord on bits 1 and 3, then bit 1 alone
        for (int j = 0; j < 10; j++) begin
            step(9'h00A, 1'b1);
            check_out("chord", 1'b0, 9'h000);
        end
        release_all();
        for (int j = 0; j < 6; j++) step(9'h002, 1'b0);
        check_out("chord_re_pre", 1'b0, 9'h000);
        step(9'h002, 1'b0);
        check_out("chord_re", 1'b1, 9'h002);
        step(9'h002, 1'b1);
        check_out("chord_re_xfer", 1'b0, 9'h000);
        exp_moves++;
        release_all();
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
        check("count_4", {24'b0, move_count}, exp_moves);
`endif

        // Asynchronous reset while emitting
        for (int j = 0; j < 7; j++) step(9'h004, 1'b0);
        check_out("rst_emit", 1'b1, 9'h004);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_async", 1'b0, 9'h000);
        exp_moves = 0;
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
        check("rst_count", {24'b0, move_count}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) step(9'h004, 1'b0);
        check_out("rst_post_pre", 1'b0, 9'h000);
        step(9'h004, 1'b0);
        check_out("rst_post", 1'b1, 9'h004);
        step(9'h004, 1'b1);
        exp_moves++;
        release_all();

        // ena low freezes the debounce counter and later the handshake
        for (int j = 0; j < 3; j++) step(9'h020, 1'b0);
        ena = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step(9'h020, 1'b0);
            check_out("ena_db", 1'b0, 9'h000);
        end
        ena = 1'b1;
        for (int j = 0; j < 3; j++) step(9'h020, 1'b0);
        check_out("ena_late", 1'b0, 9'h000);
        step(9'h020, 1'b0);
        check_out("ena_emit", 1'b1, 9'h020);
        ena = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step(9'h020, 1'b1);
            check_out("ena_hold", 1'b1, 9'h020);
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
            check("ena_count", {24'b0, move_count}, exp_moves);
`endif
        end
        ena = 1'b1;
        step(9'h020, 1'b1);
        check_out("ena_xfer", 1'b0, 9'h000);
        exp_moves++;
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
        check("ena_count_inc", {24'b0, move_count}, exp_moves);
`endif
        release_all();

`ifdef LIGHTS_OUT_MOVE_COUNT_EN
        // Saturation of the accepted-move counter
        do_reset();
        for (int m = 0; m < 260; m++) begin
            pat = 9'h001 << $urandom_range(0, 8);
            repeat (D + 4) step(pat, 1'b1);
            release_all();
            if (m == 199) check("count_200", {24'b0, move_count}, 32'd200);
        end
        check("count_sat", {24'b0, move_count}, 32'd255);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c += hold) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: pat = '0;
                4, 5, 6, 7: pat = 9'h001 << $urandom_range(0, 8);
                default:    pat = 9'($urandom_range(0, 511));
            endcase
            hold = $urandom_range(1, 12);
            for (int h = 0; h < hold; h++) begin
                ena = ($urandom_range(0, 9) != 0);
                step(pat, 1'($urandom_range(0, 1)));
                check("rand_valid", {31'b0, press_valid}, {31'b0, (m_state == 1)});
                check("rand_onehot", {23'b0, press_onehot}, {23'b0, m_oh});
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
                check("rand_count", {24'b0, move_count}, m_cnt);
`endif
            end
        end
        ena = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
